// File: rtl/cpu_pkg.sv
// Shared types and default widths for the CPU pipeline stages.
//   alu_op_t    : ALU/MUL operation select driven by the decoder.
//   fwd_sel_t   : operand forwarding source select from the hazard unit.
//   mul_state_t : iterative multiplier sequencing.
package cpu_pkg;

  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefPcW     = 9;
  localparam int unsigned DefMulBits = 4;

  typedef enum logic [3:0] {
    AluAdd = 4'b0000,
    AluSub = 4'b0001,
    AluAnd = 4'b0010,
    AluOr  = 4'b0011,
    AluXor = 4'b0100,
    AluSlt = 4'b0101,
    AluSll = 4'b0110,
    AluSrl = 4'b0111,
    AluMul = 4'b1000
  } alu_op_t;

  typedef enum logic [1:0] {
    FwdReg     = 2'b00,
    FwdResultW = 2'b01,
    FwdAluM    = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    MulIdle,
    MulBusy,
    MulDone
  } mul_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative unsigned multiplier retiring MUL_BITS multiplier bits per cycle.
// Keeps only the low DATA_W bits of the product.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start_i    : MUL instruction present in EX (only honoured in idle)
//   a_i, b_i   : operands, latched on the start cycle
//   busy_o     : stall request, high from the start cycle through the last step
//   done_o     : product_o is valid this cycle
//   product_o  : low DATA_W bits of a * b
module mul_iter import cpu_pkg::*; #(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned MUL_BITS = DefMulBits
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int unsigned Steps = DATA_W / MUL_BITS;
  localparam int unsigned CntW  = $clog2(Steps + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  mul_state_t        state_q, state_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] pp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MulIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    // Partial product of the multiplicand and the low MUL_BITS multiplier digit.
    pp = '0;
    for (int i = 0; i < int'(MUL_BITS); i++) begin
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    end

    case (state_q)
      MulIdle: begin
        if (start_i) begin
          mcand_d  = a_i;
          mplier_d = b_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MulBusy;
        end
      end
      MulBusy: begin
        acc_d    = acc_q + pp;
        mcand_d  = mcand_q << MUL_BITS;
        mplier_d = mplier_q >> MUL_BITS;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) state_d = MulDone;
      end
      // A MUL still sitting in EX during done is not restarted.
      MulDone: state_d = MulIdle;
      default: state_d = MulIdle;
    endcase
  end

  // Gated by rst so the stall drops the moment reset asserts.
  assign busy_o    = ~rst & (((state_q == MulIdle) & start_i) | (state_q == MulBusy));
  assign done_o    = (state_q == MulDone);
  assign product_o = acc_q;

endmodule

// File: rtl/execute_cycle.sv
// Pipeline EX stage: operand forwarding, ALU, branch/jump resolution and the E/M register.
// MUL runs in the iterative multiplier and stalls the front end through MulBusyE.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   RegWriteE..ALUControlE        : EX-stage control
//   RD1_E, RD2_E, ImmExtE         : operands and immediate
//   RD_E, PCE, PCPlus4E           : destination register, PC, PC+4
//   ForwardAE, ForwardBE, ResultW : forwarding selects and WB forward source
//   *M outputs                    : registered E/M pipeline register
//   PCSrcE, PCTargetE             : combinational redirect and target
//   MulBusyE                      : combinational stall request
module execute_cycle import cpu_pkg::*; #(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned PC_W     = DefPcW,
  parameter int unsigned MUL_BITS = DefMulBits
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic              ALUSrcE,
  input  logic [3:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] ImmExtE,
  input  logic [4:0]        RD_E,
  input  logic [PC_W-1:0]   PCE,
  input  logic [PC_W-1:0]   PCPlus4E,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [DATA_W-1:0] ResultW,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [4:0]        RD_M,
  output logic [PC_W-1:0]   PCPlus4M,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic              PCSrcE,
  output logic [PC_W-1:0]   PCTargetE,
  output logic              MulBusyE
);

  localparam int unsigned ShW = $clog2(DATA_W);

  alu_op_t           alu_op;
  logic [DATA_W-1:0] src_a, fwd_b, src_b, alu_res, product;
  logic [ShW-1:0]    shamt;
  logic              zero, is_mul, mul_done;

  logic              reg_write_q, reg_write_d;
  logic              mem_write_q, mem_write_d;
  logic              result_src_q, result_src_d;
  logic [4:0]        rd_q, rd_d;
  logic [PC_W-1:0]   pc_plus4_q, pc_plus4_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  assign alu_op = alu_op_t'(ALUControlE);
  assign is_mul = (alu_op == AluMul);

  always_comb begin
    case (fwd_sel_t'(ForwardAE))
      FwdResultW: src_a = ResultW;
      FwdAluM:    src_a = ALUResultM;
      default:    src_a = RD1_E;
    endcase
    case (fwd_sel_t'(ForwardBE))
      FwdResultW: fwd_b = ResultW;
      FwdAluM:    fwd_b = ALUResultM;
      default:    fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : fwd_b;
  assign shamt = src_b[ShW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      AluAdd:  alu_res = src_a + src_b;
      AluSub:  alu_res = src_a - src_b;
      AluAnd:  alu_res = src_a & src_b;
      AluOr:   alu_res = src_a | src_b;
      AluXor:  alu_res = src_a ^ src_b;
      AluSlt:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      AluSll:  alu_res = src_a << shamt;
      AluSrl:  alu_res = src_a >> shamt;
      default: alu_res = '0;
    endcase
  end

  assign zero = (alu_res == '0);

  mul_iter #(
    .DATA_W  (DATA_W),
    .MUL_BITS(MUL_BITS)
  ) u_mul_iter (
    .clk      (clk),
    .rst      (rst),
    .start_i  (is_mul),
    .a_i      (src_a),
    .b_i      (fwd_b),
    .busy_o   (MulBusyE),
    .done_o   (mul_done),
    .product_o(product)
  );

  // MUL never redirects, including its done cycle.
  assign PCSrcE    = ~MulBusyE & ~is_mul & (JumpE | (BranchE & zero));
  assign PCTargetE = PCE + ImmExtE[PC_W-1:0];

  always_comb begin
    reg_write_d  = RegWriteE & ~MulBusyE;
    mem_write_d  = MemWriteE & ~MulBusyE;
    result_src_d = ResultSrcE & ~MulBusyE;
    rd_d         = RD_E;
    pc_plus4_d   = PCPlus4E;
    alu_result_d = mul_done ? product : alu_res;
    write_data_d = fwd_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign RD_M       = rd_q;
  assign PCPlus4M   = pc_plus4_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed cases plus randomized ops against a
// behavioural model of the EX stage.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, ImmExtE, ResultW;
  logic [4:0]  RD_E;
  logic [8:0]  PCE, PCPlus4E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        RegWriteM, MemWriteM, ResultSrcM, PCSrcE, MulBusyE;
  logic [4:0]  RD_M;
  logic [8:0]  PCPlus4M, PCTargetE;
  logic [31:0] ALUResultM, WriteDataM;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_alu_m;    // model of ALUResultM
  logic        obs_pcsrc;
  logic [8:0]  obs_tgt;

  execute_cycle #(
    .DATA_W  (32),
    .PC_W    (9),
    .MUL_BITS(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteE  (RegWriteE),
    .MemWriteE  (MemWriteE),
    .ResultSrcE (ResultSrcE),
    .BranchE    (BranchE),
    .JumpE      (JumpE),
    .ALUSrcE    (ALUSrcE),
    .ALUControlE(ALUControlE),
    .RD1_E      (RD1_E),
    .RD2_E      (RD2_E),
    .ImmExtE    (ImmExtE),
    .RD_E       (RD_E),
    .PCE        (PCE),
    .PCPlus4E   (PCPlus4E),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .ResultW    (ResultW),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .RD_M       (RD_M),
    .PCPlus4M   (PCPlus4M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .MulBusyE   (MulBusyE)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd,
                                      input logic [31:0] resw, input logic [31:0] alum);
    if (sel == 2'b01) return resw;
    if (sel == 2'b10) return alum;
    return rd;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd6:    return a << (b % 32);
      4'd7:    return a >> (b % 32);
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_idle();
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; JumpE = 0; ALUSrcE = 0;
    ALUControlE = 4'd0; RD1_E = 0; RD2_E = 0; ImmExtE = 0; ResultW = 0; RD_E = 0;
    PCE = 0; PCPlus4E = 0; ForwardAE = 0; ForwardBE = 0;
  endtask

  // Called just after a rising edge with non-MUL inputs already driven.
  task automatic run_alu();
    logic [31:0] a, b, bop, res, tgt32;
    logic        exp_pc;
    #1;
    a      = fwd(ForwardAE, RD1_E, ResultW, m_alu_m);
    b      = fwd(ForwardBE, RD2_E, ResultW, m_alu_m);
    bop    = ALUSrcE ? ImmExtE : b;
    res    = ref_alu(ALUControlE, a, bop);
    exp_pc = JumpE | (BranchE & (res == 32'd0));
    tgt32  = {23'd0, PCE} + ImmExtE;
    obs_pcsrc = PCSrcE;
    obs_tgt   = PCTargetE;
    check_eq("pcsrc", PCSrcE, exp_pc);
    check_eq("pctarget", PCTargetE, tgt32[8:0]);
    check_eq("mulbusy_alu", MulBusyE, 0);
    @(posedge clk);
    #1;
    check_eq("alu_result", ALUResultM, res);
    check_eq("write_data", WriteDataM, b);
    check_eq("regwrite", RegWriteM, RegWriteE);
    check_eq("memwrite", MemWriteM, MemWriteE);
    check_eq("resultsrc", ResultSrcM, ResultSrcE);
    check_eq("rd", RD_M, RD_E);
    check_eq("pcplus4", PCPlus4M, PCPlus4E);
    m_alu_m = res;
  endtask

  task automatic run_mul(input logic [31:0] rd1, input logic [31:0] rd2, input logic [1:0] fa,
                         input logic [1:0] fb);
    logic [31:0] a, b, prod;
    int          busy_cnt;
    bit          done;
    ALUControlE = 4'd8; RD1_E = rd1; RD2_E = rd2; ForwardAE = fa; ForwardBE = fb;
    ALUSrcE = 0; BranchE = 0; JumpE = 0; MemWriteE = 0; ResultSrcE = 0; RegWriteE = 1;
    RD_E = 5'($urandom_range(1, 31));
    a    = fwd(fa, rd1, ResultW, m_alu_m);
    b    = fwd(fb, rd2, ResultW, m_alu_m);
    prod = a * b;
    busy_cnt = 0;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      if (MulBusyE) begin
        busy_cnt++;
        check_eq("mul_pcsrc", PCSrcE, 0);
        @(posedge clk);
        #1;
        check_eq("mul_bubble_rw", RegWriteM, 0);
        // Operands were latched on the start cycle; later forwards must not matter.
        ForwardAE = 2'b01;
        ForwardBE = 2'b01;
        ResultW   = $urandom;
      end else begin
        done = 1;
      end
    end
    check_eq("mul_busy_cycles", busy_cnt, 9);
    @(posedge clk);
    #1;
    check_eq("mul_result", ALUResultM, prod);
    check_eq("mul_regwrite", RegWriteM, 1);
    check_eq("mul_rd", RD_M, RD_E);
    m_alu_m = prod;
  endtask

  initial begin
    set_idle();
    m_alu_m = 0;
    rst = 1;
    #1;
    check_eq("rst_alu", ALUResultM, 0);
    check_eq("rst_regwrite", RegWriteM, 0);
    check_eq("rst_busy", MulBusyE, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    // ADD with immediate
    set_idle();
    ALUControlE = 4'd0; RD1_E = 5; ImmExtE = 7; ALUSrcE = 1; RegWriteE = 1; RD_E = 3;
    run_alu();
    check_eq("t1_add", ALUResultM, 12);

    // forwarding from ALUResultM, then from ResultW
    set_idle();
    RD1_E = 32'h8; ImmExtE = 32'h8; ALUSrcE = 1;
    run_alu();
    set_idle();
    ALUControlE = 4'd1; ForwardAE = 2'b10; RD1_E = 32'hDEAD; RD2_E = 3;
    run_alu();
    check_eq("t2_fwd_m", ALUResultM, 32'h0D);
    set_idle();
    ALUControlE = 4'd1; RD1_E = 32'h10; ForwardBE = 2'b01; ResultW = 32'h10; RD2_E = 32'h55;
    run_alu();
    check_eq("t2_fwd_w", ALUResultM, 0);

    // branches and target wrap
    set_idle();
    ALUControlE = 4'd1; BranchE = 1; RD1_E = 4; RD2_E = 4; PCE = 9'h020; ImmExtE = 32'h10;
    run_alu();
    check_eq("t3_taken", obs_pcsrc, 1);
    check_eq("t3_target", obs_tgt, 9'h030);
    PCE = 9'h1F8;
    run_alu();
    check_eq("t3_wrap", obs_tgt, 9'h008);
    RD2_E = 5;
    run_alu();
    check_eq("t3_not_taken", obs_pcsrc, 0);

    // SLT / SLL / SRL corner cases
    set_idle();
    ALUControlE = 4'd5; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
    run_alu();
    check_eq("t6_slt", ALUResultM, 1);
    ALUControlE = 4'd6; RD1_E = 1; RD2_E = 33;
    run_alu();
    check_eq("t6_sll", ALUResultM, 2);
    ALUControlE = 4'd7; RD1_E = 32'h8000_0000; RD2_E = 31;
    run_alu();
    check_eq("t6_srl", ALUResultM, 1);

    // multiply
    set_idle();
    run_mul(32'h0000_FFFF, 32'd3, 2'b00, 2'b00);
    check_eq("t4_mul", ALUResultM, 32'h0002_FFFD);
    set_idle();
    RD1_E = 7; RD2_E = 9;
    run_alu();

    // asynchronous reset in the middle of a MUL
    run_mul_abort();

    set_idle();
    RD1_E = 1; RD2_E = 1;
    run_alu();
    check_eq("t5_add_after_rst", ALUResultM, 2);

    // randomized mix
    for (int it = 0; it < 150; it++) begin
      set_idle();
      ResultW = $urandom;
      if (it % 15 == 7) begin
        run_mul($urandom, (it % 2 == 0) ? 32'($urandom_range(0, 999)) : $urandom,
                2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)));
      end else begin
        RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ResultSrcE = 1'($urandom);
        BranchE = 1'($urandom); JumpE = ($urandom_range(0, 7) == 0);
        ALUSrcE = 1'($urandom); ALUControlE = 4'($urandom_range(0, 7));
        RD1_E = $urandom;
        RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
        ImmExtE = $urandom; RD_E = 5'($urandom); PCE = 9'($urandom);
        PCPlus4E = PCE + 9'd4;
        ForwardAE = 2'($urandom_range(0, 2)); ForwardBE = 2'($urandom_range(0, 2));
      end
      if (it % 15 != 7) run_alu();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  task automatic run_mul_abort();
    set_idle();
    ALUControlE = 4'd8; RD1_E = 32'h1234; RD2_E = 32'h5678; RegWriteE = 1; RD_E = 9;
    PCPlus4E = 9'h44;
    for (int k = 0; k < 4; k++) @(posedge clk);
    #2;
    rst = 1;
    #1;
    check_eq("t5_rst_alu", ALUResultM, 0);
    check_eq("t5_rst_regwrite", RegWriteM, 0);
    check_eq("t5_rst_rd", RD_M, 0);
    check_eq("t5_rst_pc4", PCPlus4M, 0);
    check_eq("t5_rst_wdata", WriteDataM, 0);
    check_eq("t5_rst_busy", MulBusyE, 0);
    set_idle();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    m_alu_m = 0;
    @(posedge clk);
    #1;
  endtask

endmodule
